pixel_write_arbiter: RTL and testbench
======================================

// Module: pixel_write_arbiter
// PURPOSE
//  Shares the single frame-buffer pixel write port between NUM_REQ pixel producers
//  (cursor overlay, brush/line drawer, screen clear engine).
//  - Round-robin arbitration at burst granularity; a granted requester owns the port until its last beat.
//  - One registered pixel write per cycle.
//  - Transparent (COLOR_NONE) and off-screen pixels are accepted but never written.
// PARAMETERS
//  WIDTH     640  frame width in pixels; XW = $clog2(WIDTH)
//  HEIGHT    480  frame height in pixels; YW = $clog2(HEIGHT)
//  NUM_REQ   3    number of requesters, 2..8; IW = $clog2(NUM_REQ)
//  IDLE_MAX  15   idle cycles a lock owner may stall (valid low) before its lock is revoked
// PORTS
//  clk        in   1               clock
//  reset      in   1               synchronous, active-high
//  req_valid  in   [NUM_REQ]       requester i presents a pixel beat
//  req_x      in   [NUM_REQ][XW]   beat x coordinate
//  req_y      in   [NUM_REQ][YW]   beat y coordinate
//  req_color  in   [NUM_REQ][COLOR_WIDTH]  beat colour
//  req_last   in   [NUM_REQ]       beat is final beat of requester's burst
//  req_ready  out  [NUM_REQ]       beat accepted this cycle when valid&ready
//  wr_en      out  1               frame-buffer write strobe
//  wr_x       out  XW              write x
//  wr_y       out  YW              write y
//  wr_color   out  COLOR_WIDTH     write colour
//  owner      out  IW              id of current/last granted requester
//  busy       out  1               1 while in LOCKED
// BEHAVIOUR
//  Reset values
//   - wr_en=0, wr_x=0, wr_y=0, wr_color=COLOR_NONE, owner=0, busy=0, state=IDLE.
//   - RR pointer last=NUM_REQ-1, so requester 0 has first priority. idle_cnt=0.
//  Handshake
//   - req_ready is combinational from state, pointer and req_valid; at most one bit is high.
//   - Requesters hold x/y/color/last stable while valid&!ready.
//  IDLE
//   - winner = first i with req_valid[i], searching last+1, last+2, ... (mod NUM_REQ).
//   - req_ready[winner]=1; the beat is accepted the same cycle.
//   - last=0 on accepted beat -> LOCKED; owner<=winner.
//   - last=1 on accepted beat (single-beat burst) -> stay IDLE; last<=winner; owner<=winner.
//   - No valid -> stay IDLE; pointer unchanged.
//  LOCKED
//   - req_ready[owner]=req_valid[owner]; all other readies are 0.
//   - Accepted beat with last=1 -> IDLE; last<=owner.
//   - Cycle with valid[owner]=0: idle_cnt++. idle_cnt is cleared on every accepted beat.
//   - idle_cnt==IDLE_MAX with valid[owner] still 0 -> revoke: IDLE; last<=owner; no beat written.
//   - The beat arriving on the revoke cycle itself is not accepted.
//  Write path (latency 1)
//   - An accepted beat appears on wr_x/y/color the next cycle.
//   - wr_en=1 only if color!=COLOR_NONE && x<WIDTH && y<HEIGHT; such beats are still handshaken.
//   - wr_en=0 in every cycle with no accepted beat.
//   - wr_x/y/color hold their previous values when nothing is accepted.
//  Throughput and corner cases
//   - Back-to-back beats from one owner: one write per cycle, no bubbles.
//   - IDLE->grant on the same cycle as a single-beat burst: next arbitration starts the following cycle.
//   - Simultaneous valid from all requesters: strictly rotating, one burst each.
//   - Reset mid-burst: immediate return to reset values; the in-flight registered write is dropped (wr_en=0).
//  Width rules
//   - Comparisons are done at XW/YW widths; x==WIDTH-1 is valid, x==WIDTH is dropped.
//   - Pointer wraps NUM_REQ-1 -> 0.
// STRUCTURE
//  - common.sv: COLOR_WIDTH and COLOR_NONE (existing); add typedef struct packed pixel_beat_t
//    {x, y, color, last}, parameterised through XW/YW localparams.
//  - Sub-module rr_picker #(N): inputs valid[N], last_ptr; outputs one-hot grant and index.
//    Purely combinational, reusable by the other arbiters.
//  - Top level: 2-state FSM (IDLE, LOCKED), idle counter, write pipeline register.
// TESTING
//  1. Reset, valid[1] only, 1-beat (3,4,BLUE,last) -> ready[1] same cycle; next cycle wr_en=1, wr=(3,4,BLUE); owner=1.
//  2. valid[0..2] all held, each sends 2-beat bursts -> grant order 0,0,1,1,2,2,0; no interleaving; busy high mid-burst.
//  3. Owner 2 sends 4 beats back-to-back while 0 is valid -> 4 consecutive wr_en cycles, ready[0]=0 until owner 2's last.
//  4. Beat color=COLOR_NONE, and beat x=WIDTH (WIDTH=32: x=32) -> both get ready; wr_en stays 0.
//  5. Owner 0 sends a non-last beat, then drops valid for IDLE_MAX cycles -> busy falls, requester 1 is granted next cycle.
//  6. Reset asserted in the cycle after a beat is accepted mid-burst -> wr_en=0, busy=0, then requester 0 wins first.

Source files
------------

// File: rtl/pixel_write_arbiter_pkg.sv
// Shared definitions for the frame-buffer pixel write arbiter and its helpers.
package pixel_write_arbiter_pkg;

  // Pixel colour format (RGB565) and the reserved transparency key.
  localparam int COLOR_WIDTH = 16;
  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE = 16'hF81F;

  // Port ownership: IDLE arbitrates every cycle, LOCKED holds the port for one burst.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // A beat carrying the transparency key is handshaken but never written.
  function automatic logic is_opaque(input logic [COLOR_WIDTH-1:0] color);
    return color != COLOR_NONE;
  endfunction

endpackage

// File: rtl/pixel_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester after last_ptr, wrapping N-1 -> 0.
module rr_picker #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          found
);

  logic [IW-1:0] cand;
  logic          hit;

  // Scan last_ptr+1 .. last_ptr+N (mod N); the first valid candidate wins.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    hit   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand        = IW'((int'(last_ptr) + k) % N);
      hit         = !found && valid[cand];
      grant[cand] = grant[cand] | hit;
      index       = hit ? cand : index;
      found       = found | hit;
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Shares one frame-buffer pixel write port between NUM_REQ producers.
// Round-robin at burst granularity, one registered write per cycle, stalled owners lose the lock.
module pixel_write_arbiter
  import pixel_write_arbiter_pkg::*;
#(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int NUM_REQ  = 3,
  parameter int IDLE_MAX = 15,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0][XW-1:0]            req_x,
  input  logic [NUM_REQ-1:0][YW-1:0]            req_y,
  input  logic [NUM_REQ-1:0][COLOR_WIDTH-1:0]   req_color,
  input  logic [NUM_REQ-1:0]                    req_last,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic                                  wr_en,
  output logic [XW-1:0]                         wr_x,
  output logic [YW-1:0]                         wr_y,
  output logic [COLOR_WIDTH-1:0]                wr_color,
  output logic [IW-1:0]                         owner,
  output logic                                  busy
);

  localparam int CW = $clog2(IDLE_MAX + 1);
  // One extra bit so a power-of-two frame size does not wrap to zero.
  localparam logic [XW:0] X_LIMIT = (XW+1)'(WIDTH);
  localparam logic [YW:0] Y_LIMIT = (YW+1)'(HEIGHT);

  // Beat layout; lives here because its widths follow this instance's frame size.
  typedef struct packed {
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [COLOR_WIDTH-1:0] color;
    logic                   last;
  } pixel_beat_t;

  state_t               state_r;
  state_t               state_nxt;
  logic [IW-1:0]        last_ptr_r;
  logic [CW-1:0]        idle_cnt_r;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IW-1:0]        pick_idx;
  logic                 pick_found;
  logic                 accept;
  logic                 revoke;
  logic                 visible;
  logic [IW-1:0]        sel;
  pixel_beat_t          beat;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .valid    (req_valid),
    .last_ptr (last_ptr_r),
    .grant    (pick_grant),
    .index    (pick_idx),
    .found    (pick_found)
  );

  assign beat    = '{x: req_x[sel], y: req_y[sel], color: req_color[sel], last: req_last[sel]};
  assign visible = is_opaque(beat.color) && ({1'b0, beat.x} < X_LIMIT) && ({1'b0, beat.y} < Y_LIMIT);
  assign revoke  = (state_r == LOCKED) && !req_valid[owner] && (idle_cnt_r == CW'(IDLE_MAX));
  assign busy    = (state_r == LOCKED);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next state: lock on a non-final grant, release on the final beat or a stall timeout.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (accept && !beat.last) begin
          state_nxt = LOCKED;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOCKED: begin
        if ((accept && beat.last) || revoke) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = LOCKED;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake: the picker's winner in IDLE, only the owner while LOCKED.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    sel       = owner;
    case (state_r)
      IDLE: begin
        req_ready = pick_grant;
        accept    = pick_found;
        sel       = pick_idx;
      end
      LOCKED: begin
        req_ready[owner] = req_valid[owner];
        accept           = req_valid[owner];
        sel              = owner;
      end
      default: begin
        req_ready = '0;
        accept    = 1'b0;
        sel       = owner;
      end
    endcase
  end

  // Arbitration bookkeeping: owner, round-robin pointer and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= '0;
      last_ptr_r <= IW'(NUM_REQ - 1);
      idle_cnt_r <= '0;
    end else if (accept) begin
      owner      <= sel;
      idle_cnt_r <= '0;
      if (beat.last) begin
        last_ptr_r <= sel;
      end
    end else if (revoke) begin
      last_ptr_r <= owner;
      idle_cnt_r <= '0;
    end else if (state_r == LOCKED) begin
      idle_cnt_r <= idle_cnt_r + CW'(1);
    end
  end

  // Write pipeline: register the accepted beat; strobe only visible pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_x     <= '0;
      wr_y     <= '0;
      wr_color <= COLOR_NONE;
    end else if (accept) begin
      wr_en    <= visible;
      wr_x     <= beat.x;
      wr_y     <= beat.y;
      wr_color <= beat.color;
    end else begin
      wr_en    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: directed scenarios plus randomized bursts
// compared against a transaction-level reference model.
module tb_pixel_write_arbiter;
  import pixel_write_arbiter_pkg::*;

  localparam int W    = 40;
  localparam int H    = 30;
  localparam int N    = 3;
  localparam int IMAX = 15;
  localparam int XW   = $clog2(W);
  localparam int YW   = $clog2(H);
  localparam int IW   = $clog2(N);
  localparam int BLUE = 16'h001F;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [N-1:0]                  req_valid;
  logic [N-1:0][XW-1:0]          req_x;
  logic [N-1:0][YW-1:0]          req_y;
  logic [N-1:0][COLOR_WIDTH-1:0] req_color;
  logic [N-1:0]                  req_last;
  logic [N-1:0]                  req_ready;
  logic                          wr_en;
  logic [XW-1:0]                 wr_x;
  logic [YW-1:0]                 wr_y;
  logic [COLOR_WIDTH-1:0]        wr_color;
  logic [IW-1:0]                 owner;
  logic                          busy;

  always #5 clk = ~clk;

  pixel_write_arbiter #(.WIDTH(W), .HEIGHT(H), .NUM_REQ(N), .IDLE_MAX(IMAX)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_color(req_color), .req_last(req_last), .req_ready(req_ready), .wr_en(wr_en),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .owner(owner), .busy(busy)
  );

  // A queued beat; gap = cycles the producer keeps valid low before presenting it.
  typedef struct {
    int x;
    int y;
    int c;
    bit last;
    int gap;
  } beat_t;

  beat_t bq[N][$];
  int    grant_log[$];
  int    gcyc[$];
  int    cyc;
  int    ready_seen;
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model state: who holds the port, rotation pointer, stall count, expected outputs.
  bit m_locked;
  int m_owner, m_ptr, m_idle;
  bit e_wr_en;
  int e_x, e_y, e_c;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int i, input int x, input int y, input int c, input bit last, input int gap);
    beat_t b;
    b.x = x; b.y = y; b.c = c; b.last = last; b.gap = gap;
    bq[i].push_back(b);
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (bq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (bq[i].size() > 0 && bq[i][0].gap == 0) begin
        req_valid[i] = 1'b1;
        req_x[i]     = XW'(bq[i][0].x);
        req_y[i]     = YW'(bq[i][0].y);
        req_color[i] = COLOR_WIDTH'(bq[i][0].c);
        req_last[i]  = bq[i][0].last;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_owner = 0; m_ptr = N - 1; m_idle = 0;
    e_wr_en = 1'b0; e_x = 0; e_y = 0; e_c = COLOR_NONE;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < N; i++) bq[i].delete();
    drive_inputs();
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
    grant_log.delete();
    gcyc.delete();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_wr_x", wr_x, 0);
    chk("rst_wr_color", wr_color, COLOR_NONE);
    reset = 1'b0;
  endtask

  // One clock: decide the grant from the rules, check ready, advance model, check outputs.
  task automatic step();
    int    g;
    beat_t b;
    drive_inputs();
    #1;
    g = -1;
    if (!m_locked) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end else if (req_valid[m_owner]) begin
      g = m_owner;
    end
    ready_seen = int'(req_ready);
    chk("ready", ready_seen, (g >= 0) ? (1 << g) : 0);
    if (g >= 0) begin
      b       = bq[g][0];
      e_wr_en = (b.c != int'(COLOR_NONE)) && (b.x < W) && (b.y < H);
      e_x = b.x; e_y = b.y; e_c = b.c;
      grant_log.push_back(g);
      gcyc.push_back(cyc);
      m_idle = 0;
      if (!m_locked) begin
        m_owner = g;
        if (b.last) m_ptr = g; else m_locked = 1'b1;
      end else if (b.last) begin
        m_locked = 1'b0;
        m_ptr    = m_owner;
      end
    end else begin
      e_wr_en = 1'b0;
      if (m_locked) begin
        if (m_idle == IMAX) begin
          m_locked = 1'b0; m_ptr = m_owner; m_idle = 0;
        end else begin
          m_idle++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("wr_en", wr_en, e_wr_en);
    chk("wr_x", wr_x, e_x);
    chk("wr_y", wr_y, e_y);
    chk("wr_color", wr_color, e_c);
    chk("owner", owner, m_owner);
    chk("busy", busy, m_locked);
    for (int i = 0; i < N; i++) begin
      if (i == g) begin
        void'(bq[i].pop_front());
      end else if (bq[i].size() > 0 && bq[i][0].gap > 0) begin
        b = bq[i][0];
        b.gap--;
        bq[i][0] = b;
      end
    end
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int k = 0;
    while (!queues_empty() && k < max_cycles) begin
      step();
      k++;
    end
    chk(tag, queues_empty(), 1);
  endtask

  task automatic refill();
    int len, r, x, y, c, gap;
    for (int i = 0; i < N; i++) begin
      if (bq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          r   = $urandom_range(0, 19);
          gap = (j == 0) ? $urandom_range(0, 4) : (r < 14) ? 0 : (r < 19) ? $urandom_range(1, 3) : $urandom_range(16, 18);
          r   = $urandom_range(0, 9);
          x   = (r == 0) ? $urandom_range(W, 63) : (r == 1) ? W - 1 : $urandom_range(0, W - 1);
          r   = $urandom_range(0, 9);
          y   = (r == 0) ? $urandom_range(H, 31) : (r == 1) ? H - 1 : $urandom_range(0, H - 1);
          c   = ($urandom_range(0, 7) == 0) ? int'(COLOR_NONE) : $urandom_range(0, 65535);
          push(i, x, y, c, j == len - 1, gap);
        end
      end
    end
  endtask

  initial begin
    req_valid = '0; req_x = '0; req_y = '0; req_color = '0; req_last = '0;
    cyc = 0;
    do_reset(2);

    // 1: single-beat burst from requester 1.
    push(1, 3, 4, BLUE, 1'b1, 0);
    step();
    chk("t1_ready", ready_seen, 3'b010);
    chk("t1_wr_en", wr_en, 1);
    chk("t1_wr_x", wr_x, 3);
    chk("t1_wr_y", wr_y, 4);
    chk("t1_wr_color", wr_color, BLUE);
    chk("t1_owner", owner, 1);

    // 2: all three requesters with 2-beat bursts, then requester 0 again.
    do_reset(1);
    for (int i = 0; i < N; i++) begin
      push(i, i, 1, 16'h1000 + i, 1'b0, 0);
      push(i, i, 2, 16'h2000 + i, 1'b1, 0);
    end
    push(0, 9, 9, 16'h3000, 1'b1, 0);
    drain("t2_drain", 40);
    chk("t2_len", grant_log.size(), 7);
    begin
      int exp_order[7] = '{0, 0, 1, 1, 2, 2, 0};
      for (int k = 0; k < 7 && k < grant_log.size(); k++) chk("t2_order", grant_log[k], exp_order[k]);
    end

    // 3: owner 2 streams 4 beats while requester 0 waits.
    do_reset(1);
    for (int j = 0; j < 4; j++) push(2, 10 + j, 5, 16'h0400 + j, j == 3, 0);
    push(0, 1, 1, 16'h0001, 1'b1, 1);
    drain("t3_drain", 40);
    chk("t3_len", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      chk("t3_first", grant_log[0], 2);
      chk("t3_fourth", grant_log[3], 2);
      chk("t3_after", grant_log[4], 0);
      chk("t3_back2back", gcyc[3] - gcyc[0], 3);
    end

    // 4: transparent and off-screen beats are handshaken but not written.
    do_reset(1);
    push(0, 5, 5, COLOR_NONE, 1'b1, 0);
    push(0, W, 2, 16'h1234, 1'b1, 0);
    push(0, W - 1, H - 1, 16'h4321, 1'b1, 0);
    push(0, 2, H, 16'h5555, 1'b1, 0);
    step(); chk("t4_none_ready", ready_seen, 3'b001); chk("t4_none_wr", wr_en, 0);
    step(); chk("t4_xw_ready", ready_seen, 3'b001);   chk("t4_xw_wr", wr_en, 0);
    step(); chk("t4_edge_wr", wr_en, 1);
    step(); chk("t4_yh_wr", wr_en, 0);

    // 5: owner 0 stalls after a non-last beat until its lock is revoked.
    do_reset(1);
    push(0, 1, 1, 16'h0101, 1'b0, 0);
    push(0, 2, 1, 16'h0102, 1'b1, IMAX + 1);
    push(1, 3, 3, 16'h0303, 1'b1, 0);
    drain("t5_drain", 60);
    chk("t5_len", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("t5_g0", grant_log[0], 0);
      chk("t5_g1", grant_log[1], 1);
      chk("t5_g2", grant_log[2], 0);
      chk("t5_revoke_delay", gcyc[1] - gcyc[0], IMAX + 2);
    end

    // 6: reset in the cycle after a mid-burst beat is accepted.
    do_reset(1);
    push(0, 7, 7, 16'h0707, 1'b0, 0);
    push(0, 8, 7, 16'h0708, 1'b1, 0);
    push(1, 9, 9, 16'h0909, 1'b1, 0);
    step();
    chk("t6_busy_before", busy, 1);
    do_reset(1);
    push(0, 4, 4, 16'h0404, 1'b1, 0);
    push(1, 5, 5, 16'h0505, 1'b1, 0);
    step();
    chk("t6_first_winner", ready_seen, 3'b001);

    // Randomized traffic with stalls, off-screen beats and a mid-run reset.
    do_reset(1);
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset(1);
      refill();
      step();
    end
    drain("rand_drain", 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
